// File: rtl/counter_seg7_if.sv
// Display bus carrying the two active-low seven-segment patterns.
// The driver owns the bus (master); the board or a checker observes it (slave).
interface counter_seg7_if;
  logic [13:0] result;

  modport master (output result);
  modport slave  (input  result);
endinterface

// File: rtl/counter_seg7.sv
// Free-running modulo counter shown as two decimal digits on active-low
// seven-segment patterns, with the tens digit blanked when it is zero.
module counter_seg7 #(
  parameter int unsigned MAX_COUNT = 15
) (
  input  logic           clk,
  input  logic           rst,
  counter_seg7_if.master disp
);

  localparam logic [6:0] MAX_C = 7'(MAX_COUNT);
  localparam logic [6:0] BLANK = 7'b1111111;

  logic [6:0] count_q, count_d;
  logic [3:0] tens, units;
  logic [6:0] tens_seg, units_seg;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = BLANK;
    endcase
    return seg;
  endfunction

  // >= rather than == so an out-of-range value can never persist
  always_comb begin
    count_d = (count_q >= MAX_C) ? 7'd0 : count_q + 7'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 7'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Compare-subtract: the largest multiple of ten not above the count wins.
  always_comb begin
    tens  = 4'd0;
    units = count_q[3:0];
    for (int t = 1; t <= 9; t++) begin
      if (count_q >= 7'(t * 10)) begin
        tens  = 4'(t);
        units = 4'(count_q - 7'(t * 10));
      end
    end
  end

  always_comb begin
    tens_seg  = (tens == 4'd0) ? BLANK : seg_decode(tens);
    units_seg = seg_decode(units);
  end

  assign disp.result = {tens_seg, units_seg};

endmodule

// File: tb/tb_counter_seg7.sv
// Scoreboard bench for counter_seg7 at MAX_COUNT 15 and 99 side by side,
// checked against an arithmetic model of the displayed number.
module tb_counter_seg7;

  logic clk;
  logic rst;
  logic clk_run;

  counter_seg7_if if15();
  counter_seg7_if if99();

  counter_seg7 #(.MAX_COUNT(15)) dut15 (.clk(clk), .rst(rst), .disp(if15));
  counter_seg7 #(.MAX_COUNT(99)) dut99 (.clk(clk), .rst(rst), .disp(if99));

  typedef struct {
    logic [13:0] e15;
    logic [13:0] e99;
    string       tag;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;

  logic [6:0] seg_tbl [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  // Reference display: the number n as tens/units, tens blank when zero.
  function automatic logic [13:0] disp_of(int n);
    int t, u;
    t = n / 10;
    u = n % 10;
    return {(t == 0) ? 7'b1111111 : seg_tbl[t], seg_tbl[u]};
  endfunction

  initial begin
    clk     = 1'b0;
    clk_run = 1'b1;
  end

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic expect_now(string tag);
    exp_t e;
    e.e15 = disp_of(edges % 16);
    e.e99 = disp_of(edges % 100);
    e.tag = tag;
    q.push_back(e);
    ->chk_ev;
  endtask

  task automatic step(string tag);
    @(posedge clk);
    if (rst) edges++;
    #2;
    expect_now(tag);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2;
    rst   = 1'b0;
    edges = 0;
    expect_now("async_reset");
    #2;
    rst = 1'b1;
  endtask

  // Monitor: samples the display a little after each announced change.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got sample with no expectation at %0t", $time);
      end else begin
        e = q.pop_front();
        checks++;
        if (if15.result !== e.e15) begin
          errors++;
          $display("FAIL %s_max15: got %b required %b at %0t", e.tag, if15.result, e.e15, $time);
        end
        checks++;
        if (if99.result !== e.e99) begin
          errors++;
          $display("FAIL %s_max99: got %b required %b at %0t", e.tag, if99.result, e.e99, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    #1;
    expect_now("reset");
    #1;
    rst = 1'b1;

    // Deterministic sweep through 100 edges: 1,2,3, wrap of 15, 10, 99, wrap of 99.
    for (int i = 1; i <= 100; i++) step("count");

    for (int i = 0; i < 5; i++) step("pre_reset");
    reset_pulse();
    step("after_reset");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) reset_pulse();
      else step("random");
    end

    @(posedge clk);
    if (rst) edges++;
    #1;
    clk_run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #7;
      expect_now("static_clk");
    end
    #7;
    clk_run = 1'b1;
    step("resume");

    for (int i = 0; i < 50 && q.size() != 0; i++) #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
